// File: rtl/sd_write_buffer_if.sv
// ---------------------------------------------------------------------------
// sd_write_buffer_if
// Bundles the user-side fill interface and the SD block-write engine
// handshake of the sector staging buffer.
//   slave  : the buffer itself (consumes user/engine inputs, drives status,
//            start request, address and data)
//   master : the environment (user logic plus write engine)
// Signals:
//   sd_init_done                card initialised, gates the handoff
//   user_wr_en/user_wr_data     write one 16-bit word into the next slot
//   user_commit/user_sector_addr close the sector and start the send
//   buf_ready/word_count        fill status
//   sector_done                 one-cycle pulse at end of sector write
//   overflow/write_timeout      sticky error flags
//   write_ready/write_address   start request and block address to engine
//   write_data                  current word to engine
//   write_busy/write_request    engine busy flag and per-word advance pulse
// ---------------------------------------------------------------------------
interface sd_write_buffer_if;
  logic        sd_init_done;
  logic        user_wr_en;
  logic [15:0] user_wr_data;
  logic        user_commit;
  logic [31:0] user_sector_addr;
  logic        buf_ready;
  logic [8:0]  word_count;
  logic        sector_done;
  logic        overflow;
  logic        write_timeout;
  logic        write_ready;
  logic [31:0] write_address;
  logic [15:0] write_data;
  logic        write_busy;
  logic        write_request;

  modport slave (
    input  sd_init_done, user_wr_en, user_wr_data, user_commit, user_sector_addr,
    input  write_busy, write_request,
    output buf_ready, word_count, sector_done, overflow, write_timeout,
    output write_ready, write_address, write_data
  );

  modport master (
    output sd_init_done, user_wr_en, user_wr_data, user_commit, user_sector_addr,
    output write_busy, write_request,
    input  buf_ready, word_count, sector_done, overflow, write_timeout,
    input  write_ready, write_address, write_data
  );
endinterface

// File: rtl/sd_write_buffer.sv
// ---------------------------------------------------------------------------
// sd_write_buffer
// Stages one 512-byte sector (256 x 16-bit words) for the SD CMD24 write
// engine. Words are collected in FILL, the sector is handed over in ARMED
// once the card is initialised, and words are streamed out in SENDING on the
// engine's per-word request pulses. A falling busy flag ends the sector.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    sd_write_buffer_if.slave (user fill side + engine handshake)
// Parameters:
//   PAD_WORD        value sent for slots not filled before commit
//   TIMEOUT_CYCLES  watchdog limit from write_ready assertion to busy fall
// ---------------------------------------------------------------------------
module sd_write_buffer #(
  parameter logic [15:0] PAD_WORD       = 16'h0000,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input logic               clk,
  input logic               rst_n,
  sd_write_buffer_if.slave  bus
);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    ARMED   = 2'd1,
    SENDING = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_mem [0:255];
  logic [8:0]  r_wr_ptr;
  logic [8:0]  r_rd_ptr;
  logic [8:0]  r_commit_cnt;
  logic        r_buf_ready;
  logic        r_sector_done;
  logic        r_overflow;
  logic        r_timeout;
  logic        r_write_ready;
  logic [31:0] r_write_address;
  logic [15:0] r_write_data;
  logic        r_busy_q;
  logic [23:0] r_wd_cnt;

  logic        w_store;
  logic [8:0]  w_next_rd;
  logic        w_busy_fall;
  logic        w_wd_run;

  // A word is only stored in FILL while a free slot remains; any other write
  // attempt is counted as dropped.
  assign w_store     = (r_state == FILL) && bus.user_wr_en && !r_wr_ptr[8];
  assign w_next_rd   = r_rd_ptr + 9'd1;
  assign w_busy_fall = r_busy_q && !bus.write_busy;
  // Watchdog only runs while the engine actually owns the sector.
  assign w_wd_run    = ((r_state == ARMED) && r_write_ready) || (r_state == SENDING);

  // Storage array has no reset; unwritten slots are masked by the commit count.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr[7:0]] <= bus.user_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= FILL;
      r_wr_ptr        <= 9'd0;
      r_rd_ptr        <= 9'd0;
      r_commit_cnt    <= 9'd0;
      r_buf_ready     <= 1'b1;
      r_sector_done   <= 1'b0;
      r_overflow      <= 1'b0;
      r_timeout       <= 1'b0;
      r_write_ready   <= 1'b0;
      r_write_address <= 32'd0;
      r_write_data    <= PAD_WORD;
      r_busy_q        <= 1'b0;
      r_wd_cnt        <= 24'd0;
    end else begin
      r_sector_done <= 1'b0;
      r_busy_q      <= bus.write_busy;

      if (bus.user_wr_en && !w_store) begin
        r_overflow <= 1'b1;
      end

      // Counter saturates at the limit so the flag cannot be re-armed by wrap.
      if (w_wd_run) begin
        if (r_wd_cnt != TIMEOUT_CYCLES) begin
          r_wd_cnt <= r_wd_cnt + 24'd1;
        end
        if (r_wd_cnt == TIMEOUT_CYCLES - 24'd1) begin
          r_timeout <= 1'b1;
        end
      end

      case (r_state)
        FILL: begin
          if (w_store) begin
            r_wr_ptr <= r_wr_ptr + 9'd1;
          end
          // A word written on the commit cycle belongs to this sector.
          if (bus.user_commit) begin
            r_write_address <= bus.user_sector_addr;
            r_commit_cnt    <= r_wr_ptr + {8'd0, w_store};
            r_buf_ready     <= 1'b0;
            r_state         <= ARMED;
          end
        end

        ARMED: begin
          r_write_data <= (r_commit_cnt != 9'd0) ? r_mem[0] : PAD_WORD;
          if (!bus.sd_init_done) begin
            r_write_ready <= 1'b0;
          end else if (r_write_ready && bus.write_busy) begin
            r_write_ready <= 1'b0;
            r_state       <= SENDING;
          end else begin
            r_write_ready <= 1'b1;
          end
        end

        SENDING: begin
          if (w_busy_fall) begin
            r_sector_done <= 1'b1;
            r_wr_ptr      <= 9'd0;
            r_rd_ptr      <= 9'd0;
            r_wd_cnt      <= 24'd0;
            r_buf_ready   <= 1'b1;
            r_state       <= FILL;
          end else if (bus.write_request) begin
            // Pointer stops at 256; past the committed words only pad goes out.
            if (r_rd_ptr != 9'd256) begin
              r_rd_ptr <= w_next_rd;
            end
            r_write_data <= (w_next_rd < r_commit_cnt) ? r_mem[w_next_rd[7:0]] : PAD_WORD;
          end
        end

        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  assign bus.buf_ready     = r_buf_ready;
  assign bus.word_count    = r_wr_ptr;
  assign bus.sector_done   = r_sector_done;
  assign bus.overflow      = r_overflow;
  assign bus.write_timeout = r_timeout;
  assign bus.write_ready   = r_write_ready;
  assign bus.write_address = r_write_address;
  assign bus.write_data    = r_write_data;

endmodule

// File: tb/tb_sd_write_buffer.sv
// ---------------------------------------------------------------------------
// tb_sd_write_buffer
// Directed bench for sd_write_buffer. Inputs are driven and outputs sampled
// just after the falling clock edge. The engine side is modelled by a task
// that starts the sector, pulses write_request at a fixed spacing and checks
// each streamed word against a sector image the bench builds itself.
// ---------------------------------------------------------------------------
module tb_sd_write_buffer;

  localparam logic [15:0] PAD = 16'h0000;

  logic clk;
  logic rst_n;
  int   compareCount;
  int   mismatchCount;
  logic [15:0] expWords [0:255];

  sd_write_buffer_if bus ();

  sd_write_buffer #(
    .PAD_WORD       (PAD),
    .TIMEOUT_CYCLES (24'd100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One user-side cycle; write and commit are single-cycle pulses.
  task automatic applyStimulus(input logic wrEn, input logic [15:0] data,
                               input logic commit, input logic [31:0] addr);
    bus.user_wr_en       = wrEn;
    bus.user_wr_data     = data;
    bus.user_commit      = commit;
    bus.user_sector_addr = addr;
    step(1);
    bus.user_wr_en  = 1'b0;
    bus.user_commit = 1'b0;
  endtask

  task automatic doReset(input logic initDone);
    bus.sd_init_done     = initDone;
    bus.user_wr_en       = 1'b0;
    bus.user_wr_data     = 16'h0;
    bus.user_commit      = 1'b0;
    bus.user_sector_addr = 32'h0;
    bus.write_busy       = 1'b0;
    bus.write_request    = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    for (int i = 0; i < 256; i++) expWords[i] = PAD;
  endtask

  task automatic waitReady(input int maxCycles);
    for (int i = 0; i < maxCycles && bus.write_ready !== 1'b1; i++) step(1);
    checkOutput("writeReadyRise", {31'd0, bus.write_ready}, 32'd1);
  endtask

  // Engine model: start, stream 256 words plus one extra request, end.
  task automatic runSector(input logic [31:0] addr, input int gap);
    waitReady(8);
    checkOutput("writeAddress", bus.write_address, addr);
    checkOutput("word0", {16'd0, bus.write_data}, {16'd0, expWords[0]});
    bus.write_busy = 1'b1;
    step(1);
    checkOutput("writeReadyDrop", {31'd0, bus.write_ready}, 32'd0);
    for (int k = 1; k <= 256; k++) begin
      bus.write_request = 1'b1;
      step(1);
      bus.write_request = 1'b0;
      step(1);
      checkOutput($sformatf("word%0d", k), {16'd0, bus.write_data},
                  {16'd0, (k < 256) ? expWords[k] : PAD});
      step(gap - 2);
    end
    bus.write_busy = 1'b0;
    step(1);
    checkOutput("sectorDonePulse", {31'd0, bus.sector_done}, 32'd1);
    checkOutput("wordCountCleared", {23'd0, bus.word_count}, 32'd0);
    checkOutput("bufReadyBack", {31'd0, bus.buf_ready}, 32'd1);
    step(1);
    checkOutput("sectorDoneSingle", {31'd0, bus.sector_done}, 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL globalTimeout: got running, expected finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst_n = 1'b0;

    // Reset values
    doReset(1'b1);
    checkOutput("rstBufReady", {31'd0, bus.buf_ready}, 32'd1);
    checkOutput("rstWordCount", {23'd0, bus.word_count}, 32'd0);
    checkOutput("rstSectorDone", {31'd0, bus.sector_done}, 32'd0);
    checkOutput("rstOverflow", {31'd0, bus.overflow}, 32'd0);
    checkOutput("rstTimeout", {31'd0, bus.write_timeout}, 32'd0);
    checkOutput("rstWriteReady", {31'd0, bus.write_ready}, 32'd0);
    checkOutput("rstWriteAddress", bus.write_address, 32'd0);
    checkOutput("rstWriteData", {16'd0, bus.write_data}, {16'd0, PAD});

    // Full sector 0x0000..0x00FF
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b0, 32'h0);
      expWords[i] = 16'(i);
    end
    checkOutput("fullWordCount", {23'd0, bus.word_count}, 32'd256);
    checkOutput("fullBufReady", {31'd0, bus.buf_ready}, 32'd1);
    applyStimulus(1'b0, 16'h0, 1'b1, 32'h0000_1000);
    checkOutput("armedBufReady", {31'd0, bus.buf_ready}, 32'd0);
    runSector(32'h0000_1000, 16);

    // Partial sector, remainder padded
    doReset(1'b1);
    applyStimulus(1'b1, 16'hA1A1, 1'b0, 32'h0);
    applyStimulus(1'b1, 16'hB2B2, 1'b0, 32'h0);
    applyStimulus(1'b1, 16'hC3C3, 1'b0, 32'h0);
    expWords[0] = 16'hA1A1;
    expWords[1] = 16'hB2B2;
    expWords[2] = 16'hC3C3;
    applyStimulus(1'b0, 16'h0, 1'b1, 32'h0000_2000);
    runSector(32'h0000_2000, 4);

    // Overflow: 257th word dropped and never sent
    doReset(1'b1);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 16'h1000 + 16'(i), 1'b0, 32'h0);
      expWords[i] = 16'h1000 + 16'(i);
    end
    checkOutput("preOverflowFlag", {31'd0, bus.overflow}, 32'd0);
    applyStimulus(1'b1, 16'hFFFF, 1'b0, 32'h0);
    checkOutput("overflowFlag", {31'd0, bus.overflow}, 32'd1);
    checkOutput("overflowWordCount", {23'd0, bus.word_count}, 32'd256);
    applyStimulus(1'b0, 16'h0, 1'b1, 32'h0000_3000);
    runSector(32'h0000_3000, 4);

    // Init gating and inputs ignored outside FILL
    doReset(1'b0);
    applyStimulus(1'b1, 16'h5A5A, 1'b0, 32'h0);
    applyStimulus(1'b1, 16'h6B6B, 1'b0, 32'h0);
    expWords[0] = 16'h5A5A;
    expWords[1] = 16'h6B6B;
    applyStimulus(1'b0, 16'h0, 1'b1, 32'h0000_4000);
    step(5);
    checkOutput("gatedReady", {31'd0, bus.write_ready}, 32'd0);
    applyStimulus(1'b1, 16'h7777, 1'b0, 32'h0);
    checkOutput("armedWriteOverflow", {31'd0, bus.overflow}, 32'd1);
    checkOutput("armedWordCount", {23'd0, bus.word_count}, 32'd2);
    applyStimulus(1'b0, 16'h0, 1'b1, 32'hDEAD_BEEF);
    checkOutput("armedCommitIgnored", bus.write_address, 32'h0000_4000);
    bus.sd_init_done = 1'b1;
    step(1);
    checkOutput("initRiseReady", {31'd0, bus.write_ready}, 32'd1);
    bus.sd_init_done = 1'b0;
    step(1);
    checkOutput("initFallReady", {31'd0, bus.write_ready}, 32'd0);
    bus.sd_init_done = 1'b1;
    step(1);
    bus.write_request = 1'b1;
    step(1);
    bus.write_request = 1'b0;
    checkOutput("armedRequestIgnored", {16'd0, bus.write_data}, 32'h5A5A);
    runSector(32'h0000_4000, 4);

    // Word written on the commit cycle is the 10th word of the sector
    doReset(1'b1);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 16'h0100 + 16'(i), 1'b0, 32'h0);
      expWords[i] = 16'h0100 + 16'(i);
    end
    applyStimulus(1'b1, 16'h0109, 1'b1, 32'h0000_5000);
    expWords[9] = 16'h0109;
    checkOutput("simulWordCount", {23'd0, bus.word_count}, 32'd10);
    runSector(32'h0000_5000, 4);

    // Watchdog in ARMED with busy held low, then async reset while requesting
    doReset(1'b1);
    applyStimulus(1'b1, 16'h0F0F, 1'b0, 32'h0);
    applyStimulus(1'b0, 16'h0, 1'b1, 32'h0000_6000);
    waitReady(8);
    step(99);
    checkOutput("timeoutBefore", {31'd0, bus.write_timeout}, 32'd0);
    step(1);
    checkOutput("timeoutAt100", {31'd0, bus.write_timeout}, 32'd1);
    checkOutput("timeoutStillArmed", {31'd0, bus.write_ready}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncRstReady", {31'd0, bus.write_ready}, 32'd0);
    checkOutput("asyncRstTimeout", {31'd0, bus.write_timeout}, 32'd0);
    checkOutput("asyncRstBufReady", {31'd0, bus.buf_ready}, 32'd1);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Async reset mid-SENDING
    doReset(1'b1);
    applyStimulus(1'b1, 16'h1111, 1'b0, 32'h0);
    applyStimulus(1'b1, 16'h2222, 1'b0, 32'h0);
    applyStimulus(1'b0, 16'h0, 1'b1, 32'h0000_7000);
    waitReady(8);
    bus.write_busy = 1'b1;
    step(1);
    bus.write_request = 1'b1;
    step(1);
    bus.write_request = 1'b0;
    step(1);
    checkOutput("sendingWord1", {16'd0, bus.write_data}, 32'h2222);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midSendRstData", {16'd0, bus.write_data}, {16'd0, PAD});
    checkOutput("midSendRstCount", {23'd0, bus.word_count}, 32'd0);
    checkOutput("midSendRstAddr", bus.write_address, 32'd0);
    checkOutput("midSendRstBufReady", {31'd0, bus.buf_ready}, 32'd1);
    bus.write_busy = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/sd_write_buffer.md
Name: sd_write_buffer

Overview:
Sector staging buffer sitting directly upstream of the SD block-write (CMD24) engine. It collects one 512-byte sector (256 x 16-bit words) from the user side, then hands the sector and its block address to the write engine. Words are streamed out on the engine's per-word request pulses, and the end of the sector write is detected from the engine's busy flag.

Parameters:
PAD_WORD, 16'h0000, value sent for word slots not filled before commit
TIMEOUT_CYCLES, 24'd10_000_000, cycles allowed from write_ready assertion to write_busy fall before write_timeout is set

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sd_init_done  input  1  card initialised; handoff is blocked while low
user_wr_en  input  1  write user_wr_data into the next buffer slot
user_wr_data  input  16  sector word, MSB sent first by the engine
user_commit  input  1  one-cycle pulse: close the sector and send it
user_sector_addr  input  32  block address, sampled on the accepted user_commit
buf_ready  output  1  high in FILL only; writes are accepted
word_count  output  9  words currently held, 0..256
sector_done  output  1  one-cycle pulse when the engine finishes the sector
overflow  output  1  sticky: a write was dropped
write_timeout  output  1  sticky: TIMEOUT_CYCLES exceeded
write_ready  output  1  start request to the engine
write_address  output  32  block address to the engine
write_data  output  16  current word to the engine
write_busy  input  1  engine busy flag
write_request  input  1  engine one-cycle pulse: advance to the next word

Behaviour:
- Storage: 256 x 16 register array; wr_ptr is 9 bits, rd_ptr is 9 bits.
- Reset values:
  - State FILL, buf_ready=1, word_count=0.
  - sector_done=0, overflow=0, write_timeout=0.
  - write_ready=0, write_address=0, write_data=PAD_WORD.
  - rd_ptr=0, wr_ptr=0, watchdog counter=0. Array contents are don't-care.
- FILL state:
  - user_wr_en with wr_ptr<256: store the word at wr_ptr and increment wr_ptr.
  - user_wr_en with wr_ptr==256: the word is dropped and overflow is set.
  - user_commit: latch write_address from user_sector_addr and the fill level into a commit count, then go to ARMED.
  - user_wr_en and user_commit in the same cycle: the word is stored first and is part of the sector. The commit count includes it.
  - Commit with 0 words is legal; a full sector of PAD_WORD is sent.
- ARMED state:
  - buf_ready=0; write_data is loaded with slot 0 (PAD_WORD if the commit count is 0).
  - write_ready is registered: it goes high on the first cycle with sd_init_done=1.
  - It stays high until write_busy is sampled high. write_ready then drops on the next edge and the state goes to SENDING.
  - If sd_init_done falls before write_busy is seen, write_ready drops and the block waits in ARMED.
- SENDING state:
  - On each write_request pulse, rd_ptr increments and write_data is updated on the next edge.
  - The update is mem[rd_ptr+1] when rd_ptr+1 is below the commit count, otherwise PAD_WORD.
  - The new word must be stable within 2 cycles of the pulse; the engine samples it 14 cycles later.
  - rd_ptr saturates at 256. Extra requests leave write_data=PAD_WORD.
- Completion and leaving SENDING:
  - write_busy falling (sampled 1 then 0) ends the sector: sector_done pulses for one cycle.
  - On the same edge, wr_ptr, rd_ptr and word_count clear and the state returns to FILL.
  - write_request outside SENDING is ignored.
- Dropped inputs:
  - user_commit outside FILL is ignored.
  - user_wr_en outside FILL is dropped and sets overflow.
- Watchdog:
  - The counter runs in ARMED (while write_ready=1) and in SENDING, and clears on return to FILL.
  - Reaching TIMEOUT_CYCLES sets write_timeout (sticky). The state is unaffected.
- Reset mid-operation: all state returns to the reset values and write_ready drops immediately (asynchronous).
- Sticky flags clear only on reset.

Test Plan:
- Full sector: write 0x0000..0x00FF, commit addr 0x0000_1000, sd_init_done=1 -> write_ready=1 and write_address=0x0000_1000 with write_data=0x0000. After a 1-cycle write_busy rise, write_ready=0. A request pulse every 16 cycles yields write_data 0x0001..0x00FF, then PAD. A busy fall gives exactly one sector_done pulse and word_count=0.
- Partial: write 3 words 0xA1A1,0xB2B2,0xC3C3, commit with PAD_WORD=0 -> the words stream in order, then 253 slots of 0x0000.
- Overflow: 257 writes -> word_count=256, overflow=1, and the 257th word is not sent.
- Init gating: commit with sd_init_done=0 -> write_ready stays 0. Raise sd_init_done -> write_ready=1 on the next edge.
- Simultaneous: user_wr_en with user_commit as the 10th word -> the 10th word is sent and the 11th slot is PAD.
- Timeout/reset: TIMEOUT_CYCLES=100 with write_busy held 0 -> write_timeout=1 at cycle 100 and the state stays ARMED. Assert rst_n=0 mid-SENDING -> write_ready=0 immediately and all outputs return to reset values.
